// File: rtl/fixpoint_iter_ctrl.sv
// Steps a combinational next-state/property evaluator from an initial state to a fixpoint, violation or bound.
// Latency: one evaluation per cycle after accept; result registered on the edge that terminates the job.
// Backpressure: start_ready only in IDLE; the result is held in DONE until res_ready, blocking new jobs.
module fixpoint_iter_ctrl #(
    parameter int STATE_W  = 8,
    parameter int MAX_ITER = 16,
    parameter int ITER_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [STATE_W-1:0] init_state,
    input  logic               abort,
    output logic               eval_en,
    output logic [STATE_W-1:0] eval_state,
    input  logic [STATE_W-1:0] eval_next,
    input  logic               eval_prop,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_fixpoint,
    output logic               res_violation,
    output logic [ITER_W-1:0]  res_iters,
    output logic [STATE_W-1:0] res_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } fsm_t;

    typedef struct packed {
        logic               fixpoint;
        logic               violation;
        logic [ITER_W-1:0]  iters;
        logic [STATE_W-1:0] state;
    } res_t;

    fsm_t               state_q, state_d;
    logic [STATE_W-1:0] cur_q, cur_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    logic [ITER_W-1:0]  iter_inc;
    logic               last_iter;
    res_t               res_q, res_d;

    assign iter_inc  = iter_q + 1'b1;
    assign last_iter = (iter_inc == ITER_W'(MAX_ITER));

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        iter_d  = iter_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    cur_d   = init_state;
                    iter_d  = '0;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                // Termination checks are ordered: abort, violation, fixpoint, bound.
                if (abort) begin
                    state_d = IDLE;
                end else if (!eval_prop) begin
                    res_d   = '{fixpoint: 1'b0, violation: 1'b1, iters: iter_inc, state: cur_q};
                    state_d = DONE;
                end else if (eval_next == cur_q) begin
                    res_d   = '{fixpoint: 1'b1, violation: 1'b0, iters: iter_inc, state: cur_q};
                    state_d = DONE;
                end else if (last_iter) begin
                    res_d   = '{fixpoint: 1'b0, violation: 1'b0, iters: iter_inc, state: cur_q};
                    state_d = DONE;
                end else begin
                    cur_d  = eval_next;
                    iter_d = iter_inc;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            iter_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            iter_q  <= iter_d;
            res_q   <= res_d;
        end
    end

    assign start_ready   = (state_q == IDLE);
    assign eval_en       = (state_q == EVAL);
    assign res_valid     = (state_q == DONE);
    assign eval_state    = cur_q;
    assign res_fixpoint  = res_q.fixpoint;
    assign res_violation = res_q.violation;
    assign res_iters     = res_q.iters;
    assign res_state     = res_q.state;

endmodule

// File: tb/tb_fixpoint_iter_ctrl.sv
// Bench for fixpoint_iter_ctrl: directed scenarios plus randomized lookup-table evaluators
// checked against a sequential reference iteration.
module tb_fixpoint_iter_ctrl;

    localparam int STATE_W  = 8;
    localparam int MAX_ITER = 16;
    localparam int ITER_W   = 5;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start_valid = 1'b0;
    logic               start_ready;
    logic [STATE_W-1:0] init_state = '0;
    logic               abort = 1'b0;
    logic               eval_en;
    logic [STATE_W-1:0] eval_state;
    logic [STATE_W-1:0] eval_next;
    logic               eval_prop;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic               res_fixpoint;
    logic               res_violation;
    logic [ITER_W-1:0]  res_iters;
    logic [STATE_W-1:0] res_state;

    fixpoint_iter_ctrl #(.STATE_W(STATE_W), .MAX_ITER(MAX_ITER), .ITER_W(ITER_W)) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready), .init_state(init_state),
        .abort(abort), .eval_en(eval_en), .eval_state(eval_state),
        .eval_next(eval_next), .eval_prop(eval_prop),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_fixpoint(res_fixpoint), .res_violation(res_violation),
        .res_iters(res_iters), .res_state(res_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Evaluator models: 0 identity, 1 saturate at 5, 2 wrap +1, 3 stick+violate at 3, 4 random table.
    int   mode = 0;
    logic [7:0] lut_next [256];
    logic       lut_prop [256];

    function automatic logic [7:0] f_next(input logic [7:0] s);
        case (mode)
            0:       return s;
            1:       return (s < 8'd5) ? s + 8'd1 : 8'd5;
            2:       return s + 8'd1;
            3:       return (s == 8'd3) ? s : s + 8'd1;
            default: return lut_next[s];
        endcase
    endfunction

    function automatic logic f_prop(input logic [7:0] s);
        case (mode)
            3:       return (s != 8'd3);
            4:       return lut_prop[s];
            default: return 1'b1;
        endcase
    endfunction

    always_comb begin
        eval_next = f_next(eval_state);
        eval_prop = f_prop(eval_state);
    end

    // Reference result of a job, computed by plain iteration over the model.
    logic [7:0] traj [MAX_ITER];
    int         e_fp, e_viol, e_iters, e_state;
    int         lat;

    task automatic ref_run(input logic [7:0] init);
        logic [7:0] s;
        s = init;
        e_fp = 0; e_viol = 0; e_iters = 0; e_state = 0;
        for (int i = 1; i <= MAX_ITER; i++) begin
            traj[i-1] = s;
            e_iters = i;
            e_state = int'(s);
            if (!f_prop(s)) begin
                e_viol = 1;
                break;
            end
            if (f_next(s) == s) begin
                e_fp = 1;
                break;
            end
            s = f_next(s);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Accept a job at the next edge, follow the trajectory, stop at the negedge where res_valid is seen.
    task automatic run_job(input logic [7:0] init, input string tag);
        int idx;
        int got;
        ref_run(init);
        @(negedge clk);
        chk({tag, "_start_ready"}, 32'(start_ready), 32'd1);
        start_valid = 1'b1;
        init_state  = init;
        @(posedge clk);
        #1 start_valid = 1'b0;
        init_state = 8'($urandom);
        lat = 1; idx = 0; got = 0;
        for (int c = 0; c < MAX_ITER + 4 && got == 0; c++) begin
            @(negedge clk);
            if (res_valid) begin
                got = 1;
            end else begin
                chk({tag, "_eval_en"}, 32'(eval_en), 32'd1);
                if (idx < MAX_ITER) chk({tag, "_eval_state"}, 32'(eval_state), 32'(traj[idx]));
                idx++;
                @(posedge clk);
                lat++;
            end
        end
        chk({tag, "_res_valid_seen"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(e_iters + 1));
        chk({tag, "_fixpoint"}, 32'(res_fixpoint), 32'(e_fp));
        chk({tag, "_violation"}, 32'(res_violation), 32'(e_viol));
        chk({tag, "_iters"}, 32'(res_iters), 32'(e_iters));
        chk({tag, "_state"}, 32'(res_state), 32'(e_state));
    endtask

    // Hold the result for some cycles, then handshake; called from a negedge.
    task automatic release_res(input int hold, input string tag);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
            chk({tag, "_hold_iters"}, 32'(res_iters), 32'(e_iters));
            chk({tag, "_hold_state"}, 32'(res_state), 32'(e_state));
            chk({tag, "_hold_start_ready"}, 32'(start_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_rel_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_rel_start_ready"}, 32'(start_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_start_ready", 32'(start_ready), 32'd1);
        chk("rst_eval_en", 32'(eval_en), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_eval_state", 32'(eval_state), 32'd0);
        chk("rst_res_flags", 32'({res_fixpoint, res_violation}), 32'd0);
        chk("rst_res_iters", 32'(res_iters), 32'd0);
        chk("rst_res_state", 32'(res_state), 32'd0);

        // Identity model
        mode = 0;
        run_job(8'h2A, "t1");
        chk("t1_lat_const", 32'(lat), 32'd2);
        chk("t1_fp_const", 32'(res_fixpoint), 32'd1);
        chk("t1_iters_const", 32'(res_iters), 32'd1);
        chk("t1_state_const", 32'(res_state), 32'h2A);
        release_res(0, "t1");

        // Saturating counter
        mode = 1;
        run_job(8'h00, "t2");
        chk("t2_lat_const", 32'(lat), 32'd7);
        chk("t2_iters_const", 32'(res_iters), 32'd6);
        chk("t2_state_const", 32'(res_state), 32'd5);
        release_res(1, "t2");

        // Wrapping counter reaches the iteration bound
        mode = 2;
        run_job(8'h10, "t3");
        chk("t3_flags_const", 32'({res_fixpoint, res_violation}), 32'd0);
        chk("t3_iters_const", 32'(res_iters), 32'd16);
        chk("t3_state_const", 32'(res_state), 32'h1F);
        release_res(2, "t3");

        // Violation wins over a simultaneous fixpoint
        mode = 3;
        run_job(8'h00, "t4");
        chk("t4_viol_const", 32'(res_violation), 32'd1);
        chk("t4_fp_const", 32'(res_fixpoint), 32'd0);
        chk("t4_iters_const", 32'(res_iters), 32'd4);
        chk("t4_state_const", 32'(res_state), 32'd3);
        release_res(0, "t4");

        // Result backpressure with start_valid pulsing; abort ignored in DONE
        mode = 0;
        run_job(8'h55, "t5");
        for (int c = 0; c < 5; c++) begin
            start_valid = c[0];
            abort       = ~c[0];
            init_state  = 8'h99;
            @(posedge clk);
            @(negedge clk);
            chk("t5_hold_valid", 32'(res_valid), 32'd1);
            chk("t5_hold_start_ready", 32'(start_ready), 32'd0);
            chk("t5_hold_state", 32'(res_state), 32'h55);
            chk("t5_hold_iters", 32'(res_iters), 32'd1);
        end
        abort       = 1'b0;
        res_ready   = 1'b1;
        start_valid = 1'b1;
        init_state  = 8'h77;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        chk("t5_hs_start_ready", 32'(start_ready), 32'd1);
        chk("t5_hs_not_accepted", 32'(eval_en), 32'd0);
        @(posedge clk);
        #1 start_valid = 1'b0;
        @(negedge clk);
        chk("t5_accept_eval_en", 32'(eval_en), 32'd1);
        chk("t5_accept_state", 32'(eval_state), 32'h77);
        @(posedge clk);
        @(negedge clk);
        chk("t5_job2_valid", 32'(res_valid), 32'd1);
        chk("t5_job2_state", 32'(res_state), 32'h77);
        e_iters = 1; e_state = 32'h77;
        release_res(0, "t5b");

        // Abort mid-EVAL
        mode = 2;
        start_valid = 1'b1;
        init_state  = 8'h40;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t6_pre_abort_state", 32'(eval_state), 32'h43);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("t6_abort_idle", 32'(start_ready), 32'd1);
        chk("t6_abort_eval_en", 32'(eval_en), 32'd0);
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (res_valid) seen = 1;
        end
        chk("t6_abort_no_result", 32'(seen), 32'd0);

        // Synchronous reset mid-EVAL
        start_valid = 1'b1;
        init_state  = 8'h20;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_idle", 32'(start_ready), 32'd1);
        chk("t6_rst_eval_state", 32'(eval_state), 32'd0);
        chk("t6_rst_eval_en", 32'(eval_en), 32'd0);
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (res_valid) seen = 1;
        end
        chk("t6_rst_no_result", 32'(seen), 32'd0);

        // Reset while a result is pending discards it
        mode = 1;
        run_job(8'h02, "t7");
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t7_rst_drop_valid", 32'(res_valid), 32'd0);
        chk("t7_rst_drop_ready", 32'(start_ready), 32'd1);

        // Randomized lookup-table evaluators
        mode = 4;
        for (int j = 0; j < 30; j++) begin
            for (int s = 0; s < 256; s++) begin
                logic [7:0] sv;
                sv = 8'(s);
                if (j % 5 != 4 && $urandom_range(0, 3) == 0) lut_next[s] = sv;
                else lut_next[s] = 8'($urandom);
                lut_prop[s] = ($urandom_range(0, 19) != 0);
            end
            run_job(8'($urandom), "rnd");
            release_res(int'($urandom_range(0, 3)), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
